// File: rtl/local_injection_unit_pkg.sv
// ni_pkg: flit types, header field offsets, FSM states and default widths for the injection unit
package ni_pkg;
  localparam int FLIT_WIDTH       = 32;
  localparam int FLIT_SRC_WIDTH   = 4;
  localparam int BUFFERSIZE_WIDTH = 4;
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;
  localparam int HDR_LEN_OFS = 0;
  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_e;
  function automatic int hdr_dst_ofs(input int len_w);
    return HDR_LEN_OFS + len_w;
  endfunction
  function automatic int hdr_src_ofs(input int len_w, input int id_w);
    return HDR_LEN_OFS + len_w + id_w;
  endfunction
endpackage

// File: rtl/local_injection_unit_if.sv
// local_injection_unit_if: request, payload and flit-out channels between core, injector and router
interface local_injection_unit_if #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ID_WIDTH   = 4,
  parameter int P_LEN_WIDTH  = 5
) ();
  logic                    req_valid;
  logic                    req_ready;
  logic [P_ID_WIDTH-1:0]   req_dst;
  logic [P_LEN_WIDTH-1:0]  req_len;
  logic                    pl_valid;
  logic                    pl_ready;
  logic [P_DATA_WIDTH-3:0] pl_data;
  logic [P_DATA_WIDTH-1:0] out_data;
  logic                    out_data_valid;
  modport slave (
    input  req_valid, req_dst, req_len, pl_valid, pl_data,
    output req_ready, pl_ready, out_data, out_data_valid
  );
  modport master (
    output req_valid, req_dst, req_len, pl_valid, pl_data,
    input  req_ready, pl_ready, out_data, out_data_valid
  );
endinterface

// File: rtl/local_injection_unit_credit_gate.sv
// ni_credit_gate: allows a flit only while registered free slots exceed flits still in flight
module ni_credit_gate #(
  parameter int P_CREDIT_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [P_CREDIT_WIDTH-1:0] in_credits_feedback,
  input  logic                      sent,
  output logic                      can_send
);
  logic [P_CREDIT_WIDTH-1:0] credit_q;
  logic [1:0]                sent_hist_q;
  logic [1:0]                in_flight;
  // sample router credits and remember the last two sends the router has not yet accounted for
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      credit_q    <= '0;
      sent_hist_q <= '0;
    end else begin
      credit_q    <= in_credits_feedback;
      sent_hist_q <= {sent_hist_q[0], sent};
    end
  end
  assign in_flight = {1'b0, sent_hist_q[0]} + {1'b0, sent_hist_q[1]};
  assign can_send  = credit_q > P_CREDIT_WIDTH'(in_flight);
endmodule

// File: rtl/local_injection_unit.sv
// local_injection_unit: splits core packet requests into head/body/tail flits for router port 0
module local_injection_unit
  import ni_pkg::*;
#(
  parameter int P_DATA_WIDTH   = FLIT_WIDTH,
  parameter int P_ID_WIDTH     = FLIT_SRC_WIDTH,
  parameter int P_CREDIT_WIDTH = BUFFERSIZE_WIDTH,
  parameter int P_MAX_LEN      = 16,
  parameter int P_LEN_WIDTH    = $clog2(P_MAX_LEN + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [P_ID_WIDTH-1:0]     router_id,
  local_injection_unit_if.slave     bus,
  input  logic [P_CREDIT_WIDTH-1:0] in_credits_feedback,
  output logic                      busy,
  output logic                      pkt_sent
);
  localparam int DST_OFS = hdr_dst_ofs(P_LEN_WIDTH);
  localparam int SRC_OFS = hdr_src_ofs(P_LEN_WIDTH, P_ID_WIDTH);
  state_e                  state_q;
  logic [P_ID_WIDTH-1:0]   dst_q;
  logic [P_LEN_WIDTH-1:0]  len_q, rem_q, len_sat;
  logic [P_DATA_WIDTH-1:0] out_data_q, flit_d;
  logic [P_DATA_WIDTH-3:0] hdr;
  logic                    out_valid_q, pkt_sent_q, can_send, fire;
  ni_credit_gate #(.P_CREDIT_WIDTH(P_CREDIT_WIDTH)) u_gate (
    .CLK                 (CLK),
    .RST                 (RST),
    .in_credits_feedback (in_credits_feedback),
    .sent                (fire),
    .can_send            (can_send)
  );
  // clamp length, build the header and pick the flit that leaves this cycle
  always_comb begin
    len_sat = bus.req_len > P_LEN_WIDTH'(P_MAX_LEN) ? P_LEN_WIDTH'(P_MAX_LEN) : bus.req_len;
    hdr = '0;
    hdr[HDR_LEN_OFS +: P_LEN_WIDTH] = len_q;
    hdr[DST_OFS +: P_ID_WIDTH] = dst_q;
    hdr[SRC_OFS +: P_ID_WIDTH] = router_id;
    fire = can_send && (state_q == S_HEAD || (state_q == S_BODY && bus.pl_valid));
    flit_d = state_q == S_HEAD ? {len_q == '0 ? FLIT_SINGLE : FLIT_HEAD, hdr}
                               : {rem_q == P_LEN_WIDTH'(1) ? FLIT_TAIL : FLIT_BODY, bus.pl_data};
  end
  // packet FSM with registered flit output; out_data keeps its last flit between sends
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      dst_q       <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pkt_sent_q  <= 1'b0;
    end else begin
      out_valid_q <= fire;
      pkt_sent_q  <= 1'b0;
      if (fire) out_data_q <= flit_d;
      case (state_q)
        S_IDLE: if (bus.req_valid) begin
          dst_q   <= bus.req_dst;
          len_q   <= len_sat;
          state_q <= S_HEAD;
        end
        S_HEAD: if (can_send) begin
          rem_q      <= len_q;
          state_q    <= len_q == '0 ? S_IDLE : S_BODY;
          pkt_sent_q <= len_q == '0;
        end
        S_BODY: if (fire) begin
          rem_q <= rem_q - P_LEN_WIDTH'(1);
          if (rem_q == P_LEN_WIDTH'(1)) begin
            state_q    <= S_IDLE;
            pkt_sent_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.req_ready      = RST && state_q == S_IDLE;
  assign bus.pl_ready       = state_q == S_BODY && can_send;
  assign bus.out_data       = out_data_q;
  assign bus.out_data_valid = out_valid_q;
  assign busy               = state_q != S_IDLE;
  assign pkt_sent           = pkt_sent_q;
endmodule
